// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider, one bit per cycle.
// Define MDU_DIV_EN to build the divider; without it divide ops keep their timing but return 0.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic              w_step;
    logic              w_fin;

    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;
    logic [CNTW-1:0]   r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [WIDTH-1:0]  r_mcand;
    logic [PW-1:0]     r_prod;

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [WIDTH-1:0]  w_addend;
    logic [WIDTH:0]    w_sum;
    logic [PW-1:0]     w_prod_fix;
    logic [WIDTH-1:0]  w_mul_res;
    logic [WIDTH-1:0]  w_div_res;
    logic [WIDTH-1:0]  w_fin_res;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == CNTW'(1)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = (r_state == S_IDLE) && start;
        w_step     = (r_state == S_CALC);
        w_fin      = (r_state == S_FIN);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = w_fin;
    end

    // Issue-time decode: signedness per funct3, then operand magnitudes.
    always_comb begin
        w_sgn_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        w_sgn_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        w_neg_a = w_sgn_a && a[WIDTH-1];
        w_neg_b = w_sgn_b && b[WIDTH-1];
        w_mag_a = w_neg_a ? (~a + WIDTH'(1)) : a;
        w_mag_b = w_neg_b ? (~b + WIDTH'(1)) : b;
    end

    // Multiplier step: add multiplicand into upper half when multiplier LSB set, then shift right.
    always_comb begin
        w_addend   = r_prod[0] ? r_mcand : '0;
        w_sum      = {1'b0, r_prod[PW-1:WIDTH]} + {1'b0, w_addend};
        w_prod_fix = (r_neg_a ^ r_neg_b) ? (~r_prod + PW'(1)) : r_prod;
        w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod_fix[WIDTH-1:0] : w_prod_fix[PW-1:WIDTH];
        w_fin_res  = r_op[2] ? w_div_res : w_mul_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_cnt   <= CNTW'(WIDTH);
                r_op    <= op;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_mcand <= w_mag_a;
                r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            end else if (w_step) begin
                r_cnt  <= r_cnt - CNTW'(1);
                r_prod <= {w_sum, r_prod[WIDTH-1:1]};
            end
            if (w_fin) r_result <= w_fin_res;
        end
    end

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_div0;
    logic             r_ovf;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Restoring step: shift next dividend bit into remainder, commit trial subtract if non-negative.
    always_comb begin
        w_sh      = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_sh - {1'b0, r_dvsr};
        w_quo_fix = (r_neg_a ^ r_neg_b) ? (~r_quo + WIDTH'(1)) : r_quo;
        w_rem_fix = r_neg_a ? (~r_rem + WIDTH'(1)) : r_rem;
        if (r_op[1])
            w_div_res = r_div0 ? r_a_orig : (r_ovf ? '0 : w_rem_fix);
        else
            w_div_res = r_div0 ? '1 : (r_ovf ? r_a_orig : w_quo_fix);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_a_orig <= '0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_dvsr   <= w_mag_b;
            r_a_orig <= a;
            r_div0   <= (b == '0);
            r_ovf    <= w_sgn_b && op[2] && (a == MOST_NEG) && (&b);
        end else if (w_step) begin
            if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_sh[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    assign w_div_res = '0;
`endif

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at WIDTH=32; divide expectations follow MDU_DIV_EN.
module tb_mdu_iter;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dv(input logic [31:0] v);
        return DIV_EN ? v : 32'h0;
    endfunction

    // Issue one op from the current (post-edge) cycle, optionally pulse a stray start at cycle pulse_at,
    // then check latency, busy duration and result. Returns in the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string tag, input int pulse_at);
        int cyc;
        int nbusy;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        cyc = 1; nbusy = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            start = (cyc == pulse_at);
            if (cyc == pulse_at) begin op = 3'b000; a = 32'd1; b = 32'd1; end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd34);
        check({tag, " busy_cycles"}, 32'(nbusy), 32'd33);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, " result"}, result, exp);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b0; a = '0; b = '0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;

        // Multiply set, each issued in the previous op's done cycle
        do_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3", 0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min", 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max", 0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max", 0);
        do_op(3'b001, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, "MULH -3*5", 0);

        // Result held and done is a single-cycle pulse
        @(posedge clk); #1;
        check("done pulse width", {31'd0, done}, 32'd0);
        check("result hold", result, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // Divide set
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2,        dv(32'hFFFF_FFFD), "DIV -7/2", 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2,        dv(32'hFFFF_FFFF), "REM -7%2", 0);
        do_op(3'b101, 32'd100,       32'd7,        dv(32'd14),        "DIVU 100/7", 0);
        do_op(3'b111, 32'd100,       32'd7,        dv(32'd2),         "REMU 100%7", 0);
        do_op(3'b101, 32'hFFFF_FFFF, 32'd2,        dv(32'h7FFF_FFFF), "DIVU max/2", 0);
        do_op(3'b100, 32'd25,        32'd0,        dv(32'hFFFF_FFFF), "DIV 25/0", 0);
        do_op(3'b111, 32'd25,        32'd0,        dv(32'd25),        "REMU 25%0", 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd0,        dv(32'hFFFF_FFF9), "REM -7%0", 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), "DIV ovf", 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0),         "REM ovf", 0);

        // Stray start mid-op is ignored
        do_op(3'b000, 32'd7, 32'd5, 32'd35, "MUL ignore start", 5);
        do_op(3'b000, 32'd6, 32'd7, 32'd42, "MUL 6*7", 0);

        // Reset at iteration 10 aborts the op
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midop busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midop reset busy", {31'd0, busy}, 32'd0);
        check("midop reset done", {31'd0, done}, 32'd0);
        check("midop reset result", result, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (50) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            check("no done after abort", 32'(seen), 32'd0);
        end
        do_op(3'b000, 32'd3, 32'd4, 32'd12, "MUL 3*4 after reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
